// File: rtl/spdif_bmc_encoder.sv
`timescale 1ns/1ps
// S/PDIF transmitter: one-deep sample holding register, IEC 60958 subframe
// assembly (B/M/W preamble, V/U/C/P slots) and biphase-mark line coding.
module spdif_bmc_encoder #(
    parameter int BLOCK_LEN = 192
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ena,
    input  logic        i_valid,
    input  logic [23:0] i_data,
    input  logic        i_vbit,
    input  logic        i_ubit,
    input  logic        i_cbit,
    output logic        o_ready,
    output logic        o_spdif,
    output logic        o_right,
    output logic        o_block_start,
    output logic        o_underrun
);
    localparam int FW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    typedef enum logic {S_IDLE = 1'b0, S_TX = 1'b1} state_t;

    // Handshake: a sample transfers on any clock with i_valid && o_ready;
    // o_ready is high exactly while the holding register is empty.
    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_hold_full;
    logic [23:0]    r_hold_data;
    logic           r_hold_v, r_hold_u, r_hold_c;
    logic [5:0]     r_ui_cnt;
    logic [FW-1:0]  r_frame_cnt;
    logic           r_right;
    logic [27:0]    r_shift;
    logic [7:0]     r_pre;
    logic           r_spdif, r_block_start, r_underrun;

    logic           w_accept, w_load, w_take, w_underrun;
    logic           w_new_right, w_is_b, w_par;
    logic [FW-1:0]  w_frame_nxt;
    logic [26:0]    w_sub;
    logic [7:0]     w_pat;

    always_comb begin
        w_accept    = i_valid && !r_hold_full;
        // UI counter is 0 while idle, so the first full strobe starts a subframe
        w_load      = i_ena && (r_ui_cnt == 6'd0) && ((r_state == S_TX) || r_hold_full);
        w_take      = w_load && r_hold_full;
        w_underrun  = w_load && !r_hold_full;
        w_new_right = (r_state == S_TX) && !r_right;
        w_frame_nxt = r_frame_cnt;
        if ((r_state == S_TX) && r_right)
            w_frame_nxt = (r_frame_cnt == FW'(BLOCK_LEN - 1)) ? '0 : r_frame_cnt + FW'(1);
        w_is_b      = !w_new_right && (w_frame_nxt == '0);
        w_sub       = r_hold_full ? {r_hold_c, r_hold_u, r_hold_v, r_hold_data}
                                  : {1'b0, 1'b0, 1'b1, 24'h000000};
        w_par       = ^w_sub;
        w_pat       = (w_new_right ? PRE_W : (w_is_b ? PRE_B : PRE_M)) ^ {8{r_spdif}};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_load) w_state_nxt = S_TX;
            default: w_state_nxt = S_TX;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
            r_hold_v    <= 1'b0;
            r_hold_u    <= 1'b0;
            r_hold_c    <= 1'b0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_data <= i_data;
            r_hold_v    <= i_vbit;
            r_hold_u    <= i_ubit;
            r_hold_c    <= i_cbit;
        end else if (w_take) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ui_cnt      <= '0;
            r_frame_cnt   <= '0;
            r_right       <= 1'b0;
            r_shift       <= '0;
            r_pre         <= '0;
            r_spdif       <= 1'b0;
            r_block_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else if (w_load) begin
            r_spdif       <= w_pat[7];
            r_pre         <= {w_pat[6:0], 1'b0};
            r_shift       <= {w_par, w_sub};
            r_ui_cnt      <= 6'd1;
            r_right       <= w_new_right;
            r_frame_cnt   <= w_frame_nxt;
            r_block_start <= w_is_b;
            r_underrun    <= w_underrun;
        end else begin
            r_block_start <= 1'b0;
            r_underrun    <= 1'b0;
            if ((r_state == S_TX) && i_ena) begin
                r_ui_cnt <= r_ui_cnt + 6'd1;
                if (r_ui_cnt < 6'd8) begin
                    r_spdif <= r_pre[7];
                    r_pre   <= {r_pre[6:0], 1'b0};
                end else if (!r_ui_cnt[0]) begin
                    r_spdif <= ~r_spdif;
                end else begin
                    // mid-cell toggle carries a 1; LSB of the shifter is the current slot
                    if (r_shift[0]) r_spdif <= ~r_spdif;
                    r_shift <= {1'b0, r_shift[27:1]};
                end
            end
        end
    end

    assign o_ready       = !r_hold_full;
    assign o_spdif       = r_spdif;
    assign o_right       = r_right;
    assign o_block_start = r_block_start;
    assign o_underrun    = r_underrun;
endmodule

// File: tb/tb_spdif_bmc_encoder.sv
`timescale 1ns/1ps
// Bench for spdif_bmc_encoder: subframe-level waveform model checked every
// clock, plus literal UI patterns, framing, underrun and backpressure checks.
module tb_spdif_bmc_encoder;
    localparam int BLOCK_LEN = 192;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_ena, i_valid, i_vbit, i_ubit, i_cbit;
    logic [23:0] i_data;
    logic        o_ready, o_spdif, o_right, o_block_start, o_underrun;

    spdif_bmc_encoder #(.BLOCK_LEN(BLOCK_LEN)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ena(i_ena), .i_valid(i_valid),
        .i_data(i_data), .i_vbit(i_vbit), .i_ubit(i_ubit), .i_cbit(i_cbit),
        .o_ready(o_ready), .o_spdif(o_spdif), .o_right(o_right),
        .o_block_start(o_block_start), .o_underrun(o_underrun)
    );

    // ---------------- clock / strobe ----------------
    always #5 i_clk = ~i_clk;

    int ena_div = 4;
    int ena_ph  = 0;
    initial begin
        i_ena = 1'b0;
        forever begin
            @(negedge i_clk);
            ena_ph = ena_ph + 1;
            if (ena_ph >= ena_div) ena_ph = 0;
            i_ena = (ena_ph == 0);
        end
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];
    bit          cap_q[$];
    int          acc_t_q[$];
    int          bs_t_q[$];
    int          bs_cnt = 0;
    int          ur_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            if (errors <= 30)
                $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Builds each 64-UI subframe as a whole waveform, then plays it out per strobe.
    bit          m_hold_full, m_hv, m_hu, m_hc, m_active, m_right, m_emit;
    logic [23:0] m_hd;
    int          m_ui, m_frame, n_strobe;
    bit          m_wave[64];
    bit          e_spdif, e_right, e_bs, e_ur;
    logic [23:0] sf_d;
    bit          sf_v, sf_u, sf_c;

    task automatic build_wave();
        logic [7:0] pat;
        bit bits[28];
        bit lvl, par;
        pat = m_right ? 8'b1110_0100 : ((m_frame == 0) ? 8'b1110_1000 : 8'b1110_0010);
        for (int k = 0; k < 8; k++) m_wave[k] = pat[7-k] ^ e_spdif;
        for (int k = 0; k < 24; k++) bits[k] = sf_d[k];
        bits[24] = sf_v; bits[25] = sf_u; bits[26] = sf_c;
        par = 1'b0;
        for (int k = 0; k < 27; k++) par = par ^ bits[k];
        bits[27] = par;
        lvl = m_wave[7];
        for (int s = 0; s < 28; s++) begin
            lvl = ~lvl;
            m_wave[8 + 2*s] = lvl;
            if (bits[s]) lvl = ~lvl;
            m_wave[9 + 2*s] = lvl;
        end
    endtask

    initial begin
        forever begin
            @(posedge i_clk or negedge i_rst_n);
            if (!i_rst_n) begin
                m_hold_full = 0; m_active = 0; m_right = 0; m_emit = 0;
                m_ui = 0; m_frame = 0;
                e_spdif = 0; e_right = 0; e_bs = 0; e_ur = 0;
            end else begin
                bit acc;
                acc = i_valid && !m_hold_full;
                e_bs = 0; e_ur = 0; m_emit = 0;
                if (i_ena) begin
                    n_strobe = n_strobe + 1;
                    if (m_ui == 0 && (m_active || m_hold_full)) begin
                        if (!m_active) begin
                            m_active = 1; m_right = 0;
                        end else begin
                            m_right = !m_right;
                            if (!m_right) m_frame = (m_frame + 1) % BLOCK_LEN;
                        end
                        if (m_hold_full) begin
                            sf_d = m_hd; sf_v = m_hv; sf_u = m_hu; sf_c = m_hc;
                            m_hold_full = 0;
                        end else begin
                            sf_d = 24'h0; sf_v = 1; sf_u = 0; sf_c = 0;
                            e_ur = 1;
                        end
                        build_wave();
                        e_right = m_right;
                        e_bs = !m_right && (m_frame == 0);
                    end
                    if (m_active) begin
                        e_spdif = m_wave[m_ui];
                        m_emit = 1;
                        m_ui = (m_ui + 1) % 64;
                    end
                end
                if (acc) begin
                    m_hold_full = 1;
                    m_hd = i_data; m_hv = i_vbit; m_hu = i_ubit; m_hc = i_cbit;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge i_clk);
            #1;
            chk("spdif", o_spdif, e_spdif);
            chk("ready", o_ready, !m_hold_full);
            chk("right", o_right, e_right);
            chk("block_start", o_block_start, e_bs);
            chk("underrun", o_underrun, e_ur);
            if (m_emit) cap_q.push_back(o_spdif);
            if (o_block_start) begin
                bs_cnt = bs_cnt + 1;
                bs_t_q.push_back(n_strobe);
            end
            if (o_underrun) ur_cnt = ur_cnt + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [23:0] d, input logic v, input logic u, input logic c);
        bit done;
        done = 0;
        i_valid = 1'b1; i_data = d; i_vbit = v; i_ubit = u; i_cbit = c;
        for (int t = 0; t < 400 && !done; t++) begin
            if (o_ready) done = 1;
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        chk("send_timeout", done, 1'b1);
        if (done) begin
            exp_q.push_back(d);
            acc_t_q.push_back(n_strobe);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic wait_cap(input int target, input int budget);
        bit ok;
        ok = 0;
        for (int t = 0; t < budget && !ok; t++) begin
            if (cap_q.size() >= target) ok = 1;
            else @(negedge i_clk);
        end
        chk("cap_timeout", ok, 1'b1);
    endtask

    function automatic logic [7:0] pre_at(input int b);
        logic [7:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) if (b + k < cap_q.size()) p[7-k] = cap_q[b+k];
        return p;
    endfunction

    function automatic logic [1:0] pair_at(input int b, input int ui);
        logic [1:0] p;
        p = '0;
        if (b + ui + 1 < cap_q.size()) p = {cap_q[b+ui], cap_q[b+ui+1]};
        return p;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int base, bs0, ur0, bad, acc0;
        logic [63:0] w64;
        logic [23:0] dec;
        n_strobe = 0;
        i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0;
        i_vbit = 1'b0; i_ubit = 1'b0; i_cbit = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_spdif", o_spdif, 1'b0);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);

        // zero / LSB / MSB samples, then underrun
        base = cap_q.size(); bs0 = bs_cnt; ur0 = ur_cnt;
        send(24'h000000, 0, 0, 0);
        send(24'h000001, 0, 0, 0);
        send(24'h800000, 0, 0, 0);
        wait_cap(base + 6*64, 3000);
        w64 = '0;
        for (int k = 0; k < 64; k++) if (base + k < cap_q.size()) w64[63-k] = cap_q[base+k];
        chk("zero_subframe", w64, 64'hE8CC_CCCC_CCCC_CCCC);
        chk("sub1_pre_w", pre_at(base + 64), 8'b1110_0100);
        chk("sub1_lsb", pair_at(base + 64, 8), 2'b10);
        chk("sub1_par", pair_at(base + 64, 62), 2'b10);
        chk("sub2_pre_m", pre_at(base + 128), 8'b1110_0010);
        chk("sub2_msb", pair_at(base + 128, 54), 2'b01);
        chk("sub2_par", pair_at(base + 128, 62), 2'b10);
        chk("ur_pre_w", pre_at(base + 192), 8'b1110_0100);
        chk("ur_vbit", pair_at(base + 192, 56), 2'b10);
        chk("ur_par", pair_at(base + 192, 62), 2'b10);
        chk("ur_pre_m", pre_at(base + 256), 8'b1110_0010);
        bad = 0;
        for (int n = 3; n < 6; n++)
            for (int s = 4; s < 32; s++)
                if (base + 64*n + 2*s < cap_q.size() &&
                    cap_q[base + 64*n + 2*s] == cap_q[base + 64*n + 2*s - 1]) bad++;
        chk("ur_slot_edges", bad, 0);
        chk("ur_count", ur_cnt - ur0, 3);
        chk("bs_count_a", bs_cnt - bs0, 1);

        // reset in mid-subframe
        repeat (100) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_spdif", o_spdif, 1'b0);
        chk("mid_rst_ready", o_ready, 1'b1);
        chk("mid_rst_right", o_right, 1'b0);
        chk("mid_rst_bs", o_block_start, 1'b0);
        chk("mid_rst_ur", o_underrun, 1'b0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        base = cap_q.size(); bs0 = bs_cnt;
        send(24'h123456, 1, 0, 1);
        wait_cap(base + 64, 1000);
        chk("post_rst_pre_b", pre_at(base), 8'b1110_1000);
        chk("post_rst_bs", bs_cnt - bs0, 1);

        // block framing with backpressure, strobe every clock
        do_reset();
        ena_div = 1;
        @(negedge i_clk);
        base = cap_q.size(); bs0 = bs_cnt; acc0 = acc_t_q.size();
        void'(bs_t_q.size());
        exp_q.delete();
        for (int k = 0; k < 384; k++) send(24'(k + 1), k[0], k[1], k[2]);
        wait_cap(base + 384*64 + 8, 2000);
        chk("block_bs_count", bs_cnt - bs0, 2);
        if (bs_t_q.size() >= 2)
            chk("block_bs_gap", bs_t_q[bs_t_q.size()-1] - bs_t_q[bs_t_q.size()-2], 384*64);
        bad = 0;
        for (int i = acc0 + 2; i < acc_t_q.size(); i++)
            if (acc_t_q[i] - acc_t_q[i-1] != 64) bad++;
        chk("accept_spacing", bad, 0);
        bad = 0;
        for (int n = 0; n <= 384; n++) begin
            logic [7:0] want;
            want = (n % 2 == 1) ? 8'b1110_0100 : ((n % 384 == 0) ? 8'b1110_1000 : 8'b1110_0010);
            if (pre_at(base + 64*n) != want) bad++;
        end
        chk("block_preambles", bad, 0);
        for (int n = 0; n < 384; n++) begin
            dec = '0;
            for (int i = 0; i < 24; i++)
                if (base + 64*n + 9 + 2*i < cap_q.size())
                    dec[i] = cap_q[base + 64*n + 8 + 2*i] ^ cap_q[base + 64*n + 9 + 2*i];
            if (exp_q.size() > 0) chk("decoded_sample", dec, exp_q.pop_front());
            else chk("decoded_missing", 1'b1, 1'b0);
        end

        repeat (4) @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        errors = errors + 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spdif_bmc_encoder.md
# spdif_bmc_encoder

S/PDIF transmitter: accepts 24-bit PCM samples over a valid/ready handshake and serialises them as IEC 60958 subframes, with B/M/W preambles, validity/user/channel-status/parity slots and biphase-mark coding. It is the transmit-side counterpart of the S/PDIF receive chain, running on the same system clock and unit-interval (UI) enable strobe. It drives the S/PDIF line output of the EQ design.

## Interface
Parameters:
- BLOCK_LEN, 192, frames per channel-status block; a B preamble marks frame 0.

Ports:
- i_clk  in  1  system clock; all state changes on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_ena  in  1  UI strobe; one-clock pulse per half bit cell; line advances only on strobed clocks.
- i_valid  in  1  sample offered.
- i_data  in  24  PCM sample, two's complement; transmitted LSB first.
- i_vbit  in  1  validity bit for this sample.
- i_ubit  in  1  user bit for this sample.
- i_cbit  in  1  channel-status bit for this sample.
- o_ready  out  1  holding register empty; transfer when i_valid && o_ready.
- o_spdif  out  1  BMC line output, registered.
- o_right  out  1  channel of the subframe being transmitted: 0 = left, 1 = right.
- o_block_start  out  1  one-clock pulse on the strobe that emits the first UI of a B preamble.
- o_underrun  out  1  one-clock pulse when a subframe starts with an empty holding register.

## Operation
- Reset values: o_spdif=0, o_ready=1, o_right=0, o_block_start=0, o_underrun=0. Holding register empty, transmitter idle, frame counter 0, UI counter 0, line level 0.
- Storage: one holding register, loaded by the handshake, plus a subframe shift register. o_ready = holding register empty.
- Idle: o_spdif holds its level. The first accepted sample starts transmission on the next i_ena strobe, as a left B subframe. After that, transmission is continuous until reset.
- Subframe: 32 slots = 64 UIs, counted by a 6-bit UI counter that wraps 63→0.
  - Slots 0-3: preamble, 8 UIs.
  - Slots 4-27: i_data[0..23].
  - Slot 28: V. Slot 29: U. Slot 30: C.
  - Slot 31: P = XOR of slots 4-30 (even parity).
- Preamble patterns, in UI order, for line level 0 before the preamble:
  - B = 11101000
  - M = 11100010
  - W = 11100100
  - If the line level is 1, emit the bitwise inverse.
- Preamble selection:
  - Left subframe with frame counter 0 → B.
  - Other left subframes → M.
  - Right subframes → W.
  - Frame counter increments after each right subframe and wraps BLOCK_LEN-1→0.
- BMC for slots 4-31: line toggles on the first UI of every slot, and toggles again on the second UI iff the bit is 1.
- Load (UI counter = 0 strobe):
  - Holding register full → move it into the shift register and mark the holding register empty.
  - Holding register empty → load data 0, V=1, U=0, C=0, and pulse o_underrun. Channel and frame counters still advance.
- Channels alternate L, R, L, …, regardless of underrun.

## Timing
- o_spdif changes only on the clock after a strobed edge (i_ena=1). Throughput is one sample per 64 strobes.
- Transfer at clock t while idle → first preamble UI appears on o_spdif after the next strobe following t.
- o_ready rises the clock after the slot-0 strobe that empties the holding register.
- Simultaneous handshake and load on the same clock: the load takes the old holding contents and the handshake is refused, because o_ready was 0. With an empty holding register, the load underruns and the new sample is accepted for the next subframe.
- o_right and o_block_start update on the slot-0 strobe. o_right is stable for the whole subframe.
- i_ena may be asserted on consecutive clocks. No minimum spacing is required.
- Asserting i_rst_n low at any point immediately returns every output and counter to its reset value. The partial subframe is discarded and the next start is a left B subframe.

## Test plan
- Reset: assert i_rst_n low mid-subframe → o_spdif=0, o_ready=1, o_right=0, no pulses. First sample after release produces pattern 11101000 and an o_block_start pulse.
- Zero sample: left 24'h000000, V=U=C=0, i_ena every 4 clocks.
  - UIs 0-7 = 11101000.
  - Slots 4-31 = pairs 11,00,11,… alternating.
  - P=0. The next preamble (W) starts from level 0.
- LSB/parity: i_data=24'h000001 → slot 4 UIs = 1,0, P=1. i_data=24'h800000 → slot 27 mid-cell toggle, P=1.
- Block framing: stream 384 samples back-to-back.
  - B on subframes 0 and 384, M on other even subframes, W on odd subframes.
  - Exactly 2 o_block_start pulses, 384 UIs apart ×64.
- Underrun: supply one left sample then stop.
  - Right subframe carries data 0, V=1, P=1.
  - One o_underrun pulse per empty subframe.
  - BMC keeps a transition at every slot boundary.
- Backpressure: hold i_valid=1 with incrementing data → o_ready drops after one accept. Exactly one transfer per 64 strobes. No sample is lost or duplicated, checked against a decoded reference.
